// File: rtl/sram_dma_arb.sv
// rtl/sram_dma_arb.sv - single-port SRAM arbiter with a word-copy DMA engine behind the CPU
//
// The CPU always owns the SRAM port when it asks for it. A small DMA engine copies
// dma_len words from dma_src to dma_dst, one word at a time, in cycles the CPU leaves
// idle. Each word takes a read (RD), a capture (CAP) and a write (WR) cycle.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   cpu_req/ADDR/DI/WE         CPU access request, forwarded to the SRAM with priority
//   dma_start/src/dst/len      one-cycle start pulse and copy descriptor
//   dma_busy, dma_done         copy in progress / one-cycle completion pulse
//   sram_ADDR/DI/EN/WE         SRAM port, driven by the CPU or the DMA
//   sram_DO                    SRAM read data, valid one cycle after the address
module sram_dma_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_ADDR,
  input  logic [DATA_W-1:0] cpu_DI,
  input  logic              cpu_WE,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_buf;
  logic              r_busy;
  logic              r_done;

  assign dma_busy = r_busy;
  assign dma_done = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_buf   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start is only looked at here, so a start while busy is ignored.
          if (dma_start) begin
            r_src <= dma_src;
            r_dst <= dma_dst;
            r_rem <= dma_len;
            if (dma_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RD;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (!cpu_req) begin
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          // Read data is sampled here even if the CPU takes the port this cycle:
          // the CPU access only changes sram_DO after this edge.
          r_buf   <= sram_DO;
          r_state <= S_WR;
        end
        S_WR: begin
          if (!cpu_req) begin
            r_src <= r_src + ADDR_W'(1);
            r_dst <= r_dst + ADDR_W'(1);
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Port mux: CPU first, then the DMA's read or write phase, otherwise idle.
  always_comb begin
    sram_ADDR = '0;
    sram_DI   = '0;
    sram_EN   = 1'b0;
    sram_WE   = 1'b0;
    if (cpu_req) begin
      sram_ADDR = cpu_ADDR;
      sram_DI   = cpu_DI;
      sram_EN   = 1'b1;
      sram_WE   = cpu_WE;
    end else if (r_state == S_RD) begin
      sram_ADDR = r_src;
      sram_EN   = 1'b1;
    end else if (r_state == S_WR) begin
      sram_ADDR = r_dst;
      sram_DI   = r_buf;
      sram_EN   = 1'b1;
      sram_WE   = 1'b1;
    end
  end

endmodule

// File: doc/sram_dma_arb.md
Name: sram_dma_arb

Overview:
- Sits directly between the CTL processor core and the SRAM, owning the single SRAM port.
- Multiplexes CPU accesses with a word-copy DMA engine; the CPU always has priority.
- The DMA copies a block of words from src to dst using only cycles in which the CPU does not request the port.
- The CTL programs it through a start/src/dst/len interface and polls dma_busy.

Parameters:
ADDR_W, 16, SRAM word-address width
DATA_W, 32, SRAM data width
LEN_W, 16, transfer-length width (words)

Ports:
clk  input  1  single clock; all state updates on posedge clk
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU uses the SRAM port this cycle (EN or WE asserted by CTL)
cpu_ADDR  input  ADDR_W  CPU address
cpu_DI  input  DATA_W  CPU write data
cpu_WE  input  1  CPU write enable
dma_start  input  1  one-cycle pulse; latch src/dst/len and begin a copy
dma_src  input  ADDR_W  source start address
dma_dst  input  ADDR_W  destination start address
dma_len  input  LEN_W  number of words to copy
dma_busy  output  1  high while a copy is in progress
dma_done  output  1  one-cycle pulse when a copy completes
sram_ADDR  output  ADDR_W  to SRAM
sram_DI  output  DATA_W  to SRAM
sram_EN  output  1  to SRAM
sram_WE  output  1  to SRAM
sram_DO  input  DATA_W  SRAM read data; valid the cycle after the address is presented (1-cycle registered read)

Behaviour:
- Reset (async, any time, including mid-copy): state=IDLE; dma_busy=0; dma_done=0; src/dst/remaining/buffer registers=0. The copy is abandoned with no done pulse.
- Port mux (combinational):
  - cpu_req=1: sram_* = cpu_* with sram_EN=1.
  - Else, DMA in RD: ADDR=src, EN=1, WE=0.
  - Else, DMA in WR: ADDR=dst, DI=buf, EN=1, WE=1.
  - Otherwise: EN=0, WE=0, ADDR=0, DI=0.
- State machine (registered):
  - IDLE: on dma_start, latch src, dst and len into remaining.
    - len=0: stay IDLE and pulse dma_done next cycle.
    - Otherwise go to RD and set dma_busy=1.
  - RD: if cpu_req=1, hold (stall). Else the read is issued; go to CAP.
  - CAP: buf<=sram_DO; go to WR. No port use, so the CPU may use the port this cycle; sram_DO still reflects the DMA read.
  - WR: if cpu_req=1, hold. Else the write is issued; src<=src+1, dst<=dst+1, remaining<=remaining-1.
    - remaining=1: go IDLE, dma_busy<=0, dma_done<=1 for exactly one cycle.
    - Otherwise go to RD.
- Uncontended throughput: 3 cycles per word. Latency from dma_start to dma_done = 3*len+1 cycles.
- Addresses wrap modulo 2^ADDR_W; no error on wrap.
- dma_start while dma_busy=1 is ignored: no relatch, no effect.
- Overlapping regions are copied strictly ascending, word by word; no overlap correction.
- dma_done and dma_start in the same cycle: the new start is accepted (state is IDLE).
- Arithmetic is unsigned.

Test Plan:
- No contention: mem[0x100..0x103]=A0..A3; start src=0x100, dst=0x200, len=4, cpu_req=0 -> mem[0x200..0x203]=A0..A3; dma_done pulses at cycle 13 after start; dma_busy high cycles 1-12.
- CPU priority: same copy with cpu_req=1 during every RD/WR cycle for 5 cycles -> CPU reads/writes complete unmodified; copy finishes exactly 5 cycles later; copied data correct.
- CPU write in CAP cycle: cpu_WE=1 to 0x300 with value 0xDEAD during CAP -> mem[0x300]=0xDEAD and the copied word still equals the source value.
- len=0 and busy-start: start len=0 -> dma_done 1 cycle later, no SRAM write. Second dma_start mid-copy with different src -> ignored; original copy completes.
- Wrap: src=0xFFFE, dst=0x0010, len=3 -> mem[0x10..0x12]=mem[0xFFFE], mem[0xFFFF], mem[0x0000].
- Reset mid-copy: assert reset asynchronously during WR of word 2 of 4 -> dma_busy=0 immediately; no dma_done; remaining words untouched; a new start afterwards works normally.
